// File: rtl/rob_completion_arbiter_pkg.sv
// rob_completion_arbiter_pkg: unit indices, default widths and a popcount helper for the completion arbiter
package rob_completion_arbiter_pkg;
  typedef enum int {ARB_ALU = 0, ARB_MEM = 1, ARB_BR = 2} arbUnitE;
  localparam int MAX_REQ = 8;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ROB_ADDRWIDTH = 6;
  localparam int DEF_PC_WIDTH = 32;
  localparam int DEF_CNT_WIDTH = 4;
  function automatic int countOnes(input logic [MAX_REQ-1:0] v);
    countOnes = 0;
    for (int i = 0; i < MAX_REQ; i++) countOnes += int'(v[i]);
  endfunction
endpackage

// File: rtl/rob_completion_arbiter_if.sv
// rob_completion_arbiter_if: unit request bundle and commit-stage probe port of the completion arbiter
interface rob_completion_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ROB_ADDRWIDTH = 6,
  parameter int PC_WIDTH = 32,
  parameter int CNT_WIDTH = 4
);
  logic FREEZE;
  logic tFLUSH_IN;
  logic [NUM_REQ-1:0] tREQ_valid_IN;
  logic [NUM_REQ*ROB_ADDRWIDTH-1:0] tREQ_robIdx_IN;
  logic [NUM_REQ-1:0] tREQ_exp_IN;
  logic [NUM_REQ-1:0] tREQ_taken_IN;
  logic [NUM_REQ*PC_WIDTH-1:0] tREQ_targetPC_IN;
  logic [NUM_REQ-1:0] fREQ_ready_OUT;
  logic [ROB_ADDRWIDTH-1:0] fROB_probeIdx_OUT;
  logic fROB_probeSetFinBit_OUT;
  logic fROB_probeSetExpBit_OUT;
  logic fROB_probeTaken_OUT;
  logic [PC_WIDTH-1:0] fROB_probeTargetPC_OUT;
  logic [CNT_WIDTH-1:0] fARB_pending_OUT;
  modport master (
    output FREEZE, tFLUSH_IN, tREQ_valid_IN, tREQ_robIdx_IN, tREQ_exp_IN, tREQ_taken_IN, tREQ_targetPC_IN,
    input fREQ_ready_OUT, fROB_probeIdx_OUT, fROB_probeSetFinBit_OUT, fROB_probeSetExpBit_OUT,
    input fROB_probeTaken_OUT, fROB_probeTargetPC_OUT, fARB_pending_OUT
  );
  modport slave (
    input FREEZE, tFLUSH_IN, tREQ_valid_IN, tREQ_robIdx_IN, tREQ_exp_IN, tREQ_taken_IN, tREQ_targetPC_IN,
    output fREQ_ready_OUT, fROB_probeIdx_OUT, fROB_probeSetFinBit_OUT, fROB_probeSetExpBit_OUT,
    output fROB_probeTaken_OUT, fROB_probeTargetPC_OUT, fARB_pending_OUT
  );
endinterface

// File: rtl/rob_completion_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker, first requester at or after ptr wins
module rr_arbiter #(
  parameter int N = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          anyGrant
);
  // scan from farthest to nearest so the closest requester to ptr overwrites the rest
  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) grant = N'(1) << ((int'(ptr) + k) % N);
  end
  assign anyGrant = |req;
endmodule

// File: rtl/rob_completion_arbiter.sv
// rob_completion_arbiter: buffers one completion per unit and grants the ROB probe port round-robin
module rob_completion_arbiter
  import rob_completion_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ROB_ADDRWIDTH = DEF_ROB_ADDRWIDTH,
  parameter int PC_WIDTH = DEF_PC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic CLK,
  input logic RESET,
  rob_completion_arbiter_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] slotValid, nextValid, grant, accept, slotExp, slotTaken;
  logic [ROB_ADDRWIDTH-1:0] slotIdx [NUM_REQ];
  logic [PC_WIDTH-1:0] slotPc [NUM_REQ];
  logic [PW-1:0] rrPtr, gIdx;
  logic anyGrant, stall;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) uArb (
    .req(slotValid),
    .ptr(rrPtr),
    .grant(grant),
    .anyGrant(anyGrant)
  );
  assign stall = bus.FREEZE | bus.tFLUSH_IN;
  assign bus.fREQ_ready_OUT = {NUM_REQ{~stall}} & (~slotValid | grant);
  assign accept = bus.tREQ_valid_IN & bus.fREQ_ready_OUT;
  assign nextValid = bus.tFLUSH_IN ? '0 : bus.FREEZE ? slotValid : accept | (slotValid & ~grant);
  always_comb begin
    gIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) gIdx = PW'(i);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slotValid <= '0;
      slotExp <= '0;
      slotTaken <= '0;
      rrPtr <= '0;
      bus.fARB_pending_OUT <= '0;
      bus.fROB_probeIdx_OUT <= '0;
      bus.fROB_probeSetFinBit_OUT <= 1'b0;
      bus.fROB_probeSetExpBit_OUT <= 1'b0;
      bus.fROB_probeTaken_OUT <= 1'b0;
      bus.fROB_probeTargetPC_OUT <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slotIdx[i] <= '0;
        slotPc[i] <= '0;
      end
    end else begin
      slotValid <= nextValid;
      bus.fARB_pending_OUT <= CNT_WIDTH'(countOnes(MAX_REQ'(nextValid)));
      for (int i = 0; i < NUM_REQ; i++)
        if (accept[i]) begin
          slotIdx[i] <= bus.tREQ_robIdx_IN[i*ROB_ADDRWIDTH +: ROB_ADDRWIDTH];
          slotExp[i] <= bus.tREQ_exp_IN[i];
          slotTaken[i] <= bus.tREQ_taken_IN[i];
          slotPc[i] <= bus.tREQ_targetPC_IN[i*PC_WIDTH +: PC_WIDTH];
        end
      if (bus.tFLUSH_IN) begin
        rrPtr <= '0;
        bus.fROB_probeSetFinBit_OUT <= 1'b0;
      end else if (!bus.FREEZE) begin
        // a frozen cycle keeps the strobe so the pending write lands on the first live edge
        bus.fROB_probeSetFinBit_OUT <= anyGrant;
        if (anyGrant) begin
          rrPtr <= (gIdx == PW'(NUM_REQ - 1)) ? '0 : gIdx + PW'(1);
          bus.fROB_probeIdx_OUT <= slotIdx[gIdx];
          bus.fROB_probeSetExpBit_OUT <= slotExp[gIdx];
          bus.fROB_probeTaken_OUT <= slotTaken[gIdx];
          bus.fROB_probeTargetPC_OUT <= slotTaken[gIdx] ? slotPc[gIdx] : '0;
        end
      end
    end
  end
endmodule
